// File: rtl/uart_seg_console.sv
// uart_seg_console: terminal-style bridge from a UART byte receiver to a
// multi-digit 7-segment driver. Printable bytes become segment patterns that
// are written at a moving cursor into a shadow buffer and committed to the
// driver; control characters move the cursor or clear the display, and
// accepted bytes are echoed back to the UART TX through a small FIFO.
module uart_seg_console #(
  parameter int CHAR_CT    = 8,
  parameter int BYTE_W     = 8,
  parameter int ECHO_DEPTH = 4,
  parameter int ECHO_MODE  = 1
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [BYTE_W-1:0]          rx_data,
  input  logic                       rx_valid,
  output logic [7:0]                 seg_out,
  output logic [$clog2(CHAR_CT)-1:0] seg_sel,
  output logic                       seg_commit,
  output logic [$clog2(CHAR_CT)-1:0] cursor,
  output logic                       busy,
  output logic                       overflow,
  output logic [BYTE_W-1:0]          tx_data,
  output logic                       tx_load,
  input  logic                       tx_load_ok
);

  localparam int IW = $clog2(CHAR_CT);
  localparam int FW = $clog2(ECHO_DEPTH);

  localparam logic [IW-1:0] LAST_IDX = IW'(CHAR_CT - 1);
  localparam logic [FW:0]   FULL_CT  = (FW + 1)'(ECHO_DEPTH);

  localparam logic [BYTE_W-1:0] K_SP   = BYTE_W'(8'h20);
  localparam logic [BYTE_W-1:0] K_TILD = BYTE_W'(8'h7E);
  localparam logic [BYTE_W-1:0] K_DOT  = BYTE_W'(8'h2E);
  localparam logic [BYTE_W-1:0] K_DASH = BYTE_W'(8'h2D);
  localparam logic [BYTE_W-1:0] K_US   = BYTE_W'(8'h5F);
  localparam logic [BYTE_W-1:0] K_0    = BYTE_W'(8'h30);
  localparam logic [BYTE_W-1:0] K_9    = BYTE_W'(8'h39);
  localparam logic [BYTE_W-1:0] K_UA   = BYTE_W'(8'h41);
  localparam logic [BYTE_W-1:0] K_UF   = BYTE_W'(8'h46);
  localparam logic [BYTE_W-1:0] K_LA   = BYTE_W'(8'h61);
  localparam logic [BYTE_W-1:0] K_LF   = BYTE_W'(8'h66);
  localparam logic [BYTE_W-1:0] K_BS   = BYTE_W'(8'h08);
  localparam logic [BYTE_W-1:0] K_CR   = BYTE_W'(8'h0D);
  localparam logic [BYTE_W-1:0] K_FF   = BYTE_W'(8'h0C);

  typedef enum logic [1:0] {IDLE, DECODE, WRITE, CLEAR} state_t;

  function automatic logic is_printable(input logic [BYTE_W-1:0] b);
    return (b >= K_SP) && (b <= K_TILD);
  endfunction

  function automatic logic [7:0] hex_glyph(input logic [3:0] v);
    logic [7:0] g;
    case (v)
      4'h0: g = 8'h3F;  4'h1: g = 8'h06;  4'h2: g = 8'h5B;  4'h3: g = 8'h4F;
      4'h4: g = 8'h66;  4'h5: g = 8'h6D;  4'h6: g = 8'h7D;  4'h7: g = 8'h07;
      4'h8: g = 8'h7F;  4'h9: g = 8'h6F;  4'hA: g = 8'h77;  4'hB: g = 8'h7C;
      4'hC: g = 8'h39;  4'hD: g = 8'h5E;  4'hE: g = 8'h79;  default: g = 8'h71;
    endcase
    return g;
  endfunction

  // Printables without a glyph of their own show only the decimal point.
  function automatic logic [7:0] seg_lut(input logic [BYTE_W-1:0] b);
    logic [7:0] p;
    p = 8'h80;
    if (b >= K_0 && b <= K_9)        p = hex_glyph(4'(b - K_0));
    else if (b >= K_UA && b <= K_UF) p = hex_glyph(4'(b - K_UA) + 4'd10);
    else if (b >= K_LA && b <= K_LF) p = hex_glyph(4'(b - K_LA) + 4'd10);
    else if (b == K_SP)              p = 8'h00;
    else if (b == K_DASH)            p = 8'h40;
    else if (b == K_US)              p = 8'h08;
    return p;
  endfunction

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [IW-1:0]     cur_q, cur_d;
  logic [IW-1:0]     tgt_q, tgt_d;
  logic [IW-1:0]     clr_q, clr_d;
  logic [7:0]        pat_q, pat_d;
  logic [7:0]        buf_q [CHAR_CT];
  logic [7:0]        buf_d [CHAR_CT];
  logic              ovf_q, ovf_d;
  logic [BYTE_W-1:0] mem_q [ECHO_DEPTH];
  logic [BYTE_W-1:0] mem_d [ECHO_DEPTH];
  logic [FW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [FW:0]       cnt_q, cnt_d;
  logic              txl_q, txl_d;
  logic [BYTE_W-1:0] txd_q, txd_d;

  logic              push;
  logic [BYTE_W-1:0] push_data;
  logic              pop, push_ok, rx_drop;
  logic [IW-1:0]     bs_cur;

  // Console FSM: byte capture, classification, buffer write and clear sweep.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    clr_d     = clr_q;
    pat_d     = pat_q;
    buf_d     = buf_q;
    push      = 1'b0;
    push_data = '0;
    bs_cur    = (cur_q == '0) ? '0 : cur_q - IW'(1);
    case (state_q)
      IDLE: begin
        if (rx_valid && en) begin
          byte_d  = rx_data;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (byte_q == K_DOT) begin
          // Decimal point lands on the previously written digit.
          tgt_d   = cur_q - IW'(1);
          pat_d   = buf_q[cur_q - IW'(1)] | 8'h80;
          state_d = WRITE;
        end else if (is_printable(byte_q)) begin
          tgt_d   = cur_q;
          pat_d   = seg_lut(byte_q);
          state_d = WRITE;
        end else if (byte_q == K_BS) begin
          cur_d     = bs_cur;
          tgt_d     = bs_cur;
          pat_d     = 8'h00;
          state_d   = WRITE;
          push      = (ECHO_MODE == 1);
          push_data = byte_q;
        end else if (byte_q == K_CR) begin
          cur_d     = '0;
          state_d   = IDLE;
          push      = (ECHO_MODE == 1);
          push_data = byte_q;
        end else if (byte_q == K_FF) begin
          clr_d     = '0;
          state_d   = CLEAR;
          push      = (ECHO_MODE == 1);
          push_data = byte_q;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        buf_d[tgt_q] = pat_q;
        if (is_printable(byte_q)) begin
          if (byte_q != K_DOT) cur_d = cur_q + IW'(1);
          push      = (ECHO_MODE == 1) || (ECHO_MODE == 2);
          push_data = (ECHO_MODE == 2) ? BYTE_W'(pat_q) : byte_q;
        end
        state_d = IDLE;
      end
      CLEAR: begin
        buf_d[clr_q] = 8'h00;
        clr_d        = clr_q + IW'(1);
        if (clr_q == LAST_IDX) begin
          cur_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Echo FIFO, TX load pacing and sticky overflow flag.
  always_comb begin
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    txd_d   = txd_q;
    ovf_d   = ovf_q;
    pop     = (cnt_q != '0) && tx_load_ok && !txl_q;
    push_ok = push && ((cnt_q != FULL_CT) || pop);
    rx_drop = rx_valid && en && (state_q != IDLE);
    txl_d   = pop;
    if (pop) begin
      txd_d = mem_q[rp_q];
      rp_d  = rp_q + FW'(1);
    end
    if (push_ok) begin
      mem_d[wp_q] = push_data;
      wp_d        = wp_q + FW'(1);
    end
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + (FW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (FW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if ((push && !push_ok) || rx_drop) ovf_d = 1'b1;
  end

  // State and datapath registers; reset clears everything including the buffer.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      byte_q  <= '0;
      cur_q   <= '0;
      tgt_q   <= '0;
      clr_q   <= '0;
      pat_q   <= '0;
      ovf_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      txl_q   <= 1'b0;
      txd_q   <= '0;
      for (int i = 0; i < CHAR_CT; i++)    buf_q[i] <= '0;
      for (int i = 0; i < ECHO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      clr_q   <= clr_d;
      pat_q   <= pat_d;
      ovf_q   <= ovf_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      txl_q   <= txl_d;
      txd_q   <= txd_d;
      buf_q   <= buf_d;
      mem_q   <= mem_d;
    end
  end

  // Driver outputs are live only while a commit is in progress.
  always_comb begin
    seg_commit = (state_q == WRITE) || (state_q == CLEAR);
    seg_sel    = '0;
    seg_out    = 8'h00;
    if (state_q == WRITE) begin
      seg_sel = tgt_q;
      seg_out = pat_q;
    end else if (state_q == CLEAR) begin
      seg_sel = clr_q;
    end
  end

  assign cursor   = cur_q;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;
  assign tx_data  = txd_q;
  assign tx_load  = txl_q;

endmodule

// File: tb/tb_uart_seg_console.sv
// Self-checking bench for uart_seg_console: a byte-level console model
// predicts display commits, cursor and echo streams for both echo modes.
module tb_uart_seg_console;
  localparam int N = 8;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       rx_valid = 1'b0;
  logic       tx_load_ok = 1'b1;
  logic [7:0] rx_data = 8'h00;

  logic [7:0] seg_out, m2_seg_out;
  logic [2:0] seg_sel, m2_seg_sel, cursor, m2_cursor;
  logic       seg_commit, m2_seg_commit, busy, m2_busy, overflow, m2_overflow;
  logic [7:0] tx_data, m2_tx_data;
  logic       tx_load, m2_tx_load;

  uart_seg_console #(.CHAR_CT(N), .BYTE_W(8), .ECHO_DEPTH(4), .ECHO_MODE(1)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .en(en), .rx_data(rx_data), .rx_valid(rx_valid),
    .seg_out(seg_out), .seg_sel(seg_sel), .seg_commit(seg_commit), .cursor(cursor),
    .busy(busy), .overflow(overflow), .tx_data(tx_data), .tx_load(tx_load),
    .tx_load_ok(tx_load_ok));

  uart_seg_console #(.CHAR_CT(N), .BYTE_W(8), .ECHO_DEPTH(4), .ECHO_MODE(2)) dut2 (
    .sys_clk(sys_clk), .rst_n(rst_n), .en(en), .rx_data(rx_data), .rx_valid(rx_valid),
    .seg_out(m2_seg_out), .seg_sel(m2_seg_sel), .seg_commit(m2_seg_commit), .cursor(m2_cursor),
    .busy(m2_busy), .overflow(m2_overflow), .tx_data(m2_tx_data), .tx_load(m2_tx_load),
    .tx_load_ok(tx_load_ok));

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {int cyc; int sel; int pat;} cm_t;
  cm_t obs_c[$];
  int  exp_sel[$], exp_pat[$];
  int  obs_tx[$], obs_tx2[$], exp_tx[$], exp_tx2[$];
  int  tx_adj = 0;
  logic prev_txl = 1'b0;

  // Observation only: record commits and echo loads for the tests to judge.
  always @(negedge sys_clk) begin
    if (seg_commit) obs_c.push_back('{cyc, int'(seg_sel), int'(seg_out)});
    if (tx_load) begin
      obs_tx.push_back(int'(tx_data));
      if (prev_txl) tx_adj++;
    end
    if (m2_tx_load) obs_tx2.push_back(int'(m2_tx_data));
    prev_txl = tx_load;
  end

  // Behavioural console model: digits as an array, cursor as an integer.
  int hex_tbl[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                      'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
  int mcur = 0;
  int mbuf[N];

  function automatic int glyph(int b);
    if (b >= 48 && b <= 57)  return hex_tbl[b - 48];
    if (b >= 65 && b <= 70)  return hex_tbl[b - 55];
    if (b >= 97 && b <= 102) return hex_tbl[b - 87];
    if (b == 32) return 'h00;
    if (b == 45) return 'h40;
    if (b == 95) return 'h08;
    return 'h80;
  endfunction

  function automatic void model_byte(int b);
    int p, t;
    if (b == 46) begin
      t = (mcur + N - 1) % N;
      p = mbuf[t] | 'h80;
      mbuf[t] = p;
      exp_sel.push_back(t); exp_pat.push_back(p);
      exp_tx.push_back(b);  exp_tx2.push_back(p);
    end else if (b >= 32 && b <= 126) begin
      p = glyph(b);
      mbuf[mcur] = p;
      exp_sel.push_back(mcur); exp_pat.push_back(p);
      mcur = (mcur + 1) % N;
      exp_tx.push_back(b); exp_tx2.push_back(p);
    end else if (b == 8) begin
      if (mcur > 0) mcur--;
      mbuf[mcur] = 0;
      exp_sel.push_back(mcur); exp_pat.push_back(0);
      exp_tx.push_back(b);
    end else if (b == 13) begin
      mcur = 0;
      exp_tx.push_back(b);
    end else if (b == 12) begin
      for (int i = 0; i < N; i++) begin
        mbuf[i] = 0;
        exp_sel.push_back(i); exp_pat.push_back(0);
      end
      mcur = 0;
      exp_tx.push_back(b);
    end
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(posedge sys_clk); #1;
      n++;
    end
    if (busy) begin
      checks++; failures++;
      $display("FAIL wait_idle: busy=%0b still after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic send_byte(input int b, output int sc);
    @(posedge sys_clk); #1;
    rx_data = 8'(b); rx_valid = 1'b1; sc = cyc;
    @(posedge sys_clk); #1;
    rx_valid = 1'b0;
    wait_idle();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rx_valid = 1'b0; en = 1'b1;
    repeat (2) @(posedge sys_clk);
    obs_c.delete(); obs_tx.delete(); obs_tx2.delete();
    exp_sel.delete(); exp_pat.delete(); exp_tx.delete(); exp_tx2.delete();
    tx_adj = 0; mcur = 0;
    for (int i = 0; i < N; i++) mbuf[i] = 0;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge sys_clk);
    checks++; if (seg_commit !== 1'b0) begin failures++; $display("FAIL reset_commit: got %0b want 0", seg_commit); end
    checks++; if (seg_out !== 8'h00) begin failures++; $display("FAIL reset_seg_out: got %0h want 0", seg_out); end
    checks++; if (seg_sel !== 3'd0) begin failures++; $display("FAIL reset_seg_sel: got %0d want 0", seg_sel); end
    checks++; if (cursor !== 3'd0) begin failures++; $display("FAIL reset_cursor: got %0d want 0", cursor); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    checks++; if (tx_load !== 1'b0 || tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx: got load=%0b data=%0h want 0/0", tx_load, tx_data); end
  endtask

  task automatic test_basic();
    int s0, s1;
    do_reset();
    send_byte(8'h31, s0); model_byte(8'h31);
    send_byte(8'h32, s1); model_byte(8'h32);
    idle_cycles(10);
    checks++;
    if (obs_c.size() != 2) begin
      failures++; $display("FAIL basic_count: got %0d commits want 2", obs_c.size());
    end else begin
      checks++;
      if (obs_c[0].sel != 0 || obs_c[0].pat != 'h06 || obs_c[0].cyc != s0 + 2) begin
        failures++; $display("FAIL basic_c0: got sel=%0d pat=%0h cyc=%0d want sel=0 pat=06 cyc=%0d", obs_c[0].sel, obs_c[0].pat, obs_c[0].cyc, s0 + 2);
      end
      checks++;
      if (obs_c[1].sel != 1 || obs_c[1].pat != 'h5B || obs_c[1].cyc != s1 + 2) begin
        failures++; $display("FAIL basic_c1: got sel=%0d pat=%0h cyc=%0d want sel=1 pat=5b cyc=%0d", obs_c[1].sel, obs_c[1].pat, obs_c[1].cyc, s1 + 2);
      end
    end
    checks++; if (cursor !== 3'd2) begin failures++; $display("FAIL basic_cursor: got %0d want 2", cursor); end
    checks++;
    if (obs_tx.size() != 2 || obs_tx[0] != 'h31 || obs_tx[1] != 'h32) begin
      failures++; $display("FAIL basic_echo: got n=%0d first=%0h want 31,32", obs_tx.size(), (obs_tx.size() > 0) ? obs_tx[0] : -1);
    end
  endtask

  task automatic test_wrap();
    int s, b;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      b = $urandom_range(32, 126);
      if (b == 46) b = 48;
      send_byte(b, s); model_byte(b);
    end
    checks++;
    if (obs_c.size() != 9) begin
      failures++; $display("FAIL wrap_count: got %0d want 9", obs_c.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (obs_c[i].sel != exp_sel[i] || obs_c[i].pat != exp_pat[i]) begin
          failures++; $display("FAIL wrap_c%0d: got sel=%0d pat=%0h want sel=%0d pat=%0h", i, obs_c[i].sel, obs_c[i].pat, exp_sel[i], exp_pat[i]);
        end
      end
      checks++; if (obs_c[8].sel != 0) begin failures++; $display("FAIL wrap_sel9: got %0d want 0", obs_c[8].sel); end
    end
    checks++; if (cursor !== 3'd1) begin failures++; $display("FAIL wrap_cursor: got %0d want 1", cursor); end
  endtask

  task automatic test_dot_bs();
    int s;
    int req[4] = '{'h4F, 'hCF, 'h00, 'h00};
    do_reset();
    send_byte(8'h33, s); model_byte(8'h33);
    send_byte(8'h2E, s); model_byte(8'h2E);
    send_byte(8'h08, s); model_byte(8'h08);
    checks++; if (cursor !== 3'd0) begin failures++; $display("FAIL dotbs_cursor: got %0d want 0", cursor); end
    send_byte(8'h08, s); model_byte(8'h08);
    checks++;
    if (obs_c.size() != 4) begin
      failures++; $display("FAIL dotbs_count: got %0d want 4", obs_c.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_c[i].sel != 0 || obs_c[i].pat != req[i] || exp_pat[i] != req[i]) begin
          failures++; $display("FAIL dotbs_c%0d: got sel=%0d pat=%0h want sel=0 pat=%0h", i, obs_c[i].sel, obs_c[i].pat, req[i]);
        end
      end
    end
    checks++; if (cursor !== 3'd0) begin failures++; $display("FAIL dotbs_cursor2: got %0d want 0", cursor); end
  endtask

  task automatic test_clear();
    int s, n, extra;
    do_reset();
    send_byte(8'h37, s); model_byte(8'h37);
    send_byte(8'h38, s); model_byte(8'h38);
    send_byte(8'h39, s); model_byte(8'h39);
    send_byte(8'h0C, s); model_byte(8'h0C);
    checks++;
    if (obs_c.size() != 11) begin
      failures++; $display("FAIL clear_count: got %0d want 11", obs_c.size());
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (obs_c[3 + i].sel != i || obs_c[3 + i].pat != 0 || obs_c[3 + i].cyc != obs_c[3].cyc + i) begin
          failures++; $display("FAIL clear_c%0d: got sel=%0d pat=%0h cyc=%0d want sel=%0d pat=0 cyc=%0d", i, obs_c[3 + i].sel, obs_c[3 + i].pat, obs_c[3 + i].cyc, i, obs_c[3].cyc + i);
        end
      end
      checks++; if (obs_c[3].cyc != s + 2) begin failures++; $display("FAIL clear_latency: got %0d want %0d", obs_c[3].cyc, s + 2); end
    end
    checks++; if (cursor !== 3'd0) begin failures++; $display("FAIL clear_cursor: got %0d want 0", cursor); end
    // Abort a sweep with reset on its third commit.
    send_byte(8'h35, s);
    @(posedge sys_clk); #1;
    rx_data = 8'h0C; rx_valid = 1'b1;
    @(posedge sys_clk); #1;
    rx_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 30 && n < 3; k++) begin
      @(negedge sys_clk);
      if (seg_commit) n++;
      if (n == 3) rst_n = 1'b0;
    end
    checks++; if (n != 3) begin failures++; $display("FAIL clear_abort_start: got %0d commits want 3", n); end
    extra = 0;
    repeat (12) begin
      @(negedge sys_clk);
      if (seg_commit) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL clear_abort: got %0d extra commits want 0", extra); end
    checks++; if (busy !== 1'b0 || cursor !== 3'd0) begin failures++; $display("FAIL clear_abort_state: got busy=%0b cursor=%0d want 0/0", busy, cursor); end
    do_reset();
  endtask

  task automatic test_overflow();
    int s;
    do_reset();
    tx_load_ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_byte(8'h41 + i, s);
      if (i == 3) begin
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %0b want 0", overflow); end
      end
      if (i == 4) begin
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %0b want 1", overflow); end
      end
    end
    @(posedge sys_clk); #1;
    tx_load_ok = 1'b1;
    idle_cycles(30);
    checks++;
    if (obs_tx.size() != 4) begin
      failures++; $display("FAIL ovf_drain: got %0d loads want 4", obs_tx.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_tx[i] != 'h41 + i) begin failures++; $display("FAIL ovf_tx%0d: got %0h want %0h", i, obs_tx[i], 'h41 + i); end
      end
    end
    checks++; if (tx_adj != 0) begin failures++; $display("FAIL ovf_adjacent: got %0d adjacent loads want 0", tx_adj); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
  endtask

  task automatic test_busy_drop();
    do_reset();
    @(posedge sys_clk); #1;
    rx_data = 8'h41; rx_valid = 1'b1;
    @(posedge sys_clk); #1;
    rx_data = 8'h42;
    @(posedge sys_clk); #1;
    rx_valid = 1'b0;
    wait_idle();
    idle_cycles(4);
    checks++;
    if (obs_c.size() != 1 || obs_c[0].sel != 0 || obs_c[0].pat != 'h77) begin
      failures++; $display("FAIL busy_drop_commits: got n=%0d want 1 (sel0,77)", obs_c.size());
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL busy_drop_ovf: got %0b want 1", overflow); end
    checks++; if (cursor !== 3'd1) begin failures++; $display("FAIL busy_drop_cursor: got %0d want 1", cursor); end
  endtask

  task automatic test_mode2();
    int s;
    do_reset();
    send_byte(8'h41, s);
    idle_cycles(8);
    checks++;
    if (obs_tx2.size() != 1 || obs_tx2[0] != 'h77) begin
      failures++; $display("FAIL mode2_echo: got n=%0d data=%0h want 77", obs_tx2.size(), (obs_tx2.size() > 0) ? obs_tx2[0] : -1);
    end
    checks++;
    if (obs_tx.size() != 1 || obs_tx[0] != 'h41) begin
      failures++; $display("FAIL mode1_echo: got n=%0d want 1 byte 41", obs_tx.size());
    end
  endtask

  task automatic test_random();
    int s, b, cat;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cat = $urandom_range(0, 9);
      if (cat <= 5) b = $urandom_range(32, 126);
      else if (cat == 6) b = 8;
      else if (cat == 7) b = 13;
      else if (cat == 8) b = 12;
      else begin
        b = $urandom_range(0, 1) ? $urandom_range(0, 31) : $urandom_range(127, 255);
      end
      en = ($urandom_range(0, 7) != 0);
      send_byte(b, s);
      if (en) model_byte(b);
      en = 1'b1;
    end
    idle_cycles(20);
    checks++;
    if (obs_c.size() != exp_sel.size()) begin
      failures++; $display("FAIL rand_count: got %0d commits want %0d", obs_c.size(), exp_sel.size());
    end else begin
      for (int i = 0; i < obs_c.size(); i++) begin
        checks++;
        if (obs_c[i].sel != exp_sel[i] || obs_c[i].pat != exp_pat[i]) begin
          failures++; $display("FAIL rand_c%0d: got sel=%0d pat=%0h want sel=%0d pat=%0h", i, obs_c[i].sel, obs_c[i].pat, exp_sel[i], exp_pat[i]);
        end
      end
    end
    checks++; if (int'(cursor) != mcur) begin failures++; $display("FAIL rand_cursor: got %0d want %0d", cursor, mcur); end
    checks++; if (obs_tx != exp_tx) begin failures++; $display("FAIL rand_echo1: got %0d bytes want %0d", obs_tx.size(), exp_tx.size()); end
    checks++; if (obs_tx2 != exp_tx2) begin failures++; $display("FAIL rand_echo2: got %0d bytes want %0d", obs_tx2.size(), exp_tx2.size()); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rand_overflow: got %0b want 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_dot_bs();
    test_clear();
    test_overflow();
    test_busy_drop();
    test_mode2();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
